// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single RAM port B between instruction fetch and
// the load/store unit, formats sub-word loads, and turns byte/halfword stores
// into a read-modify-write pair because the RAM has no byte enables.
//
// Handshake (both requesters): req and its payload stay stable until gnt is
// seen high in the same cycle; gnt is combinational and the request is consumed
// on that clock edge. Read data returns exactly one cycle after the grant on
// the matching Dv output, which is high for a single cycle.
module mem_port_arbiter #(
    parameter int cXLEN        = 32,
    parameter int cAddrW       = 10,
    parameter int cStarveLimit = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iFetchReq,
    input  logic [cXLEN-1:0]  iFetchAddr,
    output logic              oFetchGnt,
    output logic              oFetchDv,
    output logic [cXLEN-1:0]  oFetchData,
    input  logic              iLsReq,
    input  logic              iLsWrite,
    input  logic [2:0]        iLsOpType,
    input  logic [cXLEN-1:0]  iLsAddr,
    input  logic [cXLEN-1:0]  iLsWData,
    input  logic [4:0]        iLsRdAddr,
    output logic              oLsGnt,
    output logic              oLsDv,
    output logic [cXLEN-1:0]  oLsData,
    output logic [4:0]        oLsRdAddr,
    output logic              oLsErr,
    output logic              oRamEn,
    output logic              oRamWEn,
    output logic [cAddrW-1:0] oRamAddr,
    output logic [cXLEN-1:0]  oRamWData,
    input  logic [cXLEN-1:0]  iRamRData
);

    localparam int cCntW = $clog2(cStarveLimit + 1);
    localparam logic [cCntW-1:0] cLimit = cCntW'(cStarveLimit);

    typedef enum logic {ST_ARB, ST_RMW_WR} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_FETCH, TAG_LS} tag_t;

    state_t             state_q, state_d;
    tag_t               tag_q, tag_d;
    logic [cCntW-1:0]   starve_q, starve_d;
    logic [1:0]         ld_shift_q, ld_shift_d;
    logic [2:0]         ld_op_q, ld_op_d;
    logic [4:0]         ld_rd_q, ld_rd_d;
    logic [cAddrW-1:0]  rmw_addr_q, rmw_addr_d;
    logic [cXLEN-1:0]   rmw_data_q, rmw_data_d;
    logic [cXLEN-1:0]   rmw_mask_q, rmw_mask_d;

    logic               fetch_gnt, ls_gnt, ls_err;
    logic               ram_en, ram_wen;
    logic [cAddrW-1:0]  ram_addr;
    logic [cXLEN-1:0]   ram_wdata;
    logic               ls_misalign, fetch_wins;
    logic [4:0]         lane_shift;
    logic [cXLEN-1:0]   ld_word, ld_fmt;
    logic               fetch_dv, ls_dv;
    logic               unused_addr_bits;

    // Only the word-address slice of each byte address reaches the RAM.
    assign unused_addr_bits = ^{iFetchAddr[cXLEN-1:cAddrW+2], iFetchAddr[1:0],
                                iLsAddr[cXLEN-1:cAddrW+2]};

    // Arbitration, RAM port drive, RMW sequencing and starvation counting.
    always_comb begin
        state_d    = state_q;
        tag_d      = TAG_NONE;
        starve_d   = starve_q;
        ld_shift_d = ld_shift_q;
        ld_op_d    = ld_op_q;
        ld_rd_d    = ld_rd_q;
        rmw_addr_d = rmw_addr_q;
        rmw_data_d = rmw_data_q;
        rmw_mask_d = rmw_mask_q;
        fetch_gnt  = 1'b0;
        ls_gnt     = 1'b0;
        ls_err     = 1'b0;
        ram_en     = 1'b0;
        ram_wen    = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;

        ls_misalign = ((iLsOpType[1:0] == 2'b01) && iLsAddr[0]) ||
                      ((iLsOpType[1:0] == 2'b10) && (iLsAddr[1:0] != 2'b00));
        fetch_wins  = iFetchReq && (starve_q == cLimit);
        lane_shift  = {iLsAddr[1:0], 3'b000};

        case (state_q)
            ST_ARB: begin
                if (iLsReq && !fetch_wins) begin
                    ls_gnt = 1'b1;
                    if (ls_misalign) begin
                        // Rejected without touching the port.
                        ls_err = 1'b1;
                    end else if (!iLsWrite) begin
                        ram_en     = 1'b1;
                        ram_addr   = iLsAddr[cAddrW+1:2];
                        tag_d      = TAG_LS;
                        ld_shift_d = iLsAddr[1:0];
                        ld_op_d    = iLsOpType;
                        ld_rd_d    = iLsRdAddr;
                    end else if (iLsOpType[1:0] == 2'b10) begin
                        ram_en    = 1'b1;
                        ram_wen   = 1'b1;
                        ram_addr  = iLsAddr[cAddrW+1:2];
                        ram_wdata = iLsWData;
                    end else begin
                        // Sub-word store: read the old word now, merge next cycle.
                        ram_en     = 1'b1;
                        ram_addr   = iLsAddr[cAddrW+1:2];
                        rmw_addr_d = iLsAddr[cAddrW+1:2];
                        rmw_data_d = iLsWData << lane_shift;
                        rmw_mask_d = (iLsOpType[0] ? cXLEN'(16'hFFFF) : cXLEN'(8'hFF)) << lane_shift;
                        state_d    = ST_RMW_WR;
                    end
                end
                // Fetch takes the port whenever LS left it unused.
                if (iFetchReq && !ram_en) begin
                    fetch_gnt = 1'b1;
                    ram_en    = 1'b1;
                    ram_addr  = iFetchAddr[cAddrW+1:2];
                    tag_d     = TAG_FETCH;
                end
            end
            ST_RMW_WR: begin
                ram_en    = 1'b1;
                ram_wen   = 1'b1;
                ram_addr  = rmw_addr_q;
                ram_wdata = (iRamRData & ~rmw_mask_q) | (rmw_data_q & rmw_mask_q);
                state_d   = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase

        if (!iFetchReq || fetch_gnt) begin
            starve_d = '0;
        end else if (starve_q != cLimit) begin
            starve_d = starve_q + cCntW'(1);
        end
    end

    // Lane extraction and sign/zero extension of the returning load word.
    always_comb begin
        ld_word = iRamRData >> {ld_shift_q, 3'b000};
        case (ld_op_q)
            3'b000:  ld_fmt = {{(cXLEN-8){ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_fmt = {{(cXLEN-16){ld_word[15]}}, ld_word[15:0]};
            3'b100:  ld_fmt = {{(cXLEN-8){1'b0}}, ld_word[7:0]};
            3'b101:  ld_fmt = {{(cXLEN-16){1'b0}}, ld_word[15:0]};
            default: ld_fmt = ld_word;
        endcase
    end

    // State, tag and latched request registers.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= ST_ARB;
            tag_q      <= TAG_NONE;
            starve_q   <= '0;
            ld_shift_q <= '0;
            ld_op_q    <= '0;
            ld_rd_q    <= '0;
            rmw_addr_q <= '0;
            rmw_data_q <= '0;
            rmw_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            starve_q   <= starve_d;
            ld_shift_q <= ld_shift_d;
            ld_op_q    <= ld_op_d;
            ld_rd_q    <= ld_rd_d;
            rmw_addr_q <= rmw_addr_d;
            rmw_data_q <= rmw_data_d;
            rmw_mask_q <= rmw_mask_d;
        end
    end

    // Reset forces every output low, which also cancels an in-flight RMW write.
    assign fetch_dv   = !iRst && (tag_q == TAG_FETCH);
    assign ls_dv      = !iRst && (tag_q == TAG_LS);
    assign oFetchGnt  = !iRst && fetch_gnt;
    assign oLsGnt     = !iRst && ls_gnt;
    assign oLsErr     = !iRst && ls_err;
    assign oRamEn     = !iRst && ram_en;
    assign oRamWEn    = !iRst && ram_wen;
    assign oRamAddr   = iRst ? '0 : ram_addr;
    assign oRamWData  = iRst ? '0 : ram_wdata;
    assign oFetchDv   = fetch_dv;
    assign oFetchData = fetch_dv ? iRamRData : '0;
    assign oLsDv      = ls_dv;
    assign oLsData    = ls_dv ? ld_fmt : '0;
    assign oLsRdAddr  = ls_dv ? ld_rd_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        iRst;
    logic        iFetchReq;
    logic [31:0] iFetchAddr;
    logic        oFetchGnt, oFetchDv;
    logic [31:0] oFetchData;
    logic        iLsReq, iLsWrite;
    logic [2:0]  iLsOpType;
    logic [31:0] iLsAddr, iLsWData;
    logic [4:0]  iLsRdAddr;
    logic        oLsGnt, oLsDv, oLsErr;
    logic [31:0] oLsData;
    logic [4:0]  oLsRdAddr;
    logic        oRamEn, oRamWEn;
    logic [9:0]  oRamAddr;
    logic [31:0] oRamWData;
    logic [31:0] ram_rdata = '0;

    logic [31:0] mem [0:1023];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    logic [31:0] fetch_exp_q[$];
    logic [31:0] ls_exp_q[$];
    logic [31:0] rd_exp_q[$];
    bit          fetch_due = 1'b0;
    bit          ls_due = 1'b0;
    int          tests_run = 0;
    int          fail_cnt = 0;

    mem_port_arbiter #(.cXLEN(32), .cAddrW(10), .cStarveLimit(4)) dut (
        .iClk(clk), .iRst(iRst),
        .iFetchReq(iFetchReq), .iFetchAddr(iFetchAddr), .oFetchGnt(oFetchGnt),
        .oFetchDv(oFetchDv), .oFetchData(oFetchData),
        .iLsReq(iLsReq), .iLsWrite(iLsWrite), .iLsOpType(iLsOpType), .iLsAddr(iLsAddr),
        .iLsWData(iLsWData), .iLsRdAddr(iLsRdAddr), .oLsGnt(oLsGnt), .oLsDv(oLsDv),
        .oLsData(oLsData), .oLsRdAddr(oLsRdAddr), .oLsErr(oLsErr),
        .oRamEn(oRamEn), .oRamWEn(oRamWEn), .oRamAddr(oRamAddr), .oRamWData(oRamWData),
        .iRamRData(ram_rdata)
    );

    // Clock
    always #5 clk = ~clk;

    // RAM model: read-first, 1-cycle read latency, plus a backdoor write port.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (oRamEn) begin
            if (oRamWEn) mem[oRamAddr] <= oRamWData;
            ram_rdata <= mem[oRamAddr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            fail_cnt++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: a grant in the previous cycle must produce exactly one Dv now.
    task automatic sb_check();
        check("fetch_dv", {31'd0, oFetchDv}, {31'd0, fetch_due});
        if (fetch_due && fetch_exp_q.size() > 0) check("fetch_data", oFetchData, fetch_exp_q.pop_front());
        check("ls_dv", {31'd0, oLsDv}, {31'd0, ls_due});
        if (ls_due && ls_exp_q.size() > 0) begin
            check("ls_data", oLsData, ls_exp_q.pop_front());
            check("ls_rd", {27'd0, oLsRdAddr}, rd_exp_q.pop_front());
        end
        fetch_due = 1'b0;
        ls_due = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sb_check();
    endtask

    task automatic exp_fetch(input logic [31:0] d);
        fetch_exp_q.push_back(d);
        fetch_due = 1'b1;
    endtask

    task automatic exp_ls(input logic [31:0] d, input logic [4:0] rd);
        ls_exp_q.push_back(d);
        rd_exp_q.push_back({27'd0, rd});
        ls_due = 1'b1;
    endtask

    task automatic drive_fetch(input logic req, input logic [31:0] addr);
        iFetchReq = req;
        iFetchAddr = addr;
    endtask

    task automatic drive_ls(input logic req, input logic wr, input logic [2:0] op,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        iLsReq = req; iLsWrite = wr; iLsOpType = op;
        iLsAddr = addr; iLsWData = wd; iLsRdAddr = rd;
    endtask

    task automatic idle();
        drive_fetch(1'b0, 32'h0);
        drive_ls(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic bd_write(input logic [9:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [2:0]  ld_op   [6];
    logic [31:0] ld_addr [6];
    logic [31:0] ld_exp  [6];

    initial begin
        ld_op   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
        ld_addr = '{32'h7, 32'h7, 32'h6, 32'h4, 32'h5, 32'h4};
        ld_exp  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80AA, 32'h000055CC, 32'h00000055, 32'h80AA55CC};

        iRst = 1'b1;
        idle();
        repeat (3) tick();
        iRst = 1'b0;
        #1;
        check("rst_fetch_gnt", {31'd0, oFetchGnt}, 32'd0);
        check("rst_ls_gnt", {31'd0, oLsGnt}, 32'd0);
        check("rst_ram_en", {31'd0, oRamEn}, 32'd0);
        check("rst_ls_err", {31'd0, oLsErr}, 32'd0);
        tick();

        bd_write(10'd0, 32'hA0000000);
        bd_write(10'd1, 32'hA0000001);
        bd_write(10'd2, 32'hA0000002);

        // Fetch stream, three back-to-back words.
        for (int i = 0; i < 3; i++) begin
            drive_fetch(1'b1, 32'(i * 4));
            #1;
            check("f_gnt", {31'd0, oFetchGnt}, 32'd1);
            check("f_ram_en", {31'd0, oRamEn}, 32'd1);
            check("f_ram_wen", {31'd0, oRamWEn}, 32'd0);
            check("f_ram_addr", {22'd0, oRamAddr}, 32'(i));
            exp_fetch(32'hA0000000 + 32'(i));
            tick();
        end
        idle();
        #1;
        check("idle_ram_en", {31'd0, oRamEn}, 32'd0);
        tick();

        // Sub-word loads from word 1, issued back to back.
        bd_write(10'd1, 32'h80AA55CC);
        for (int i = 0; i < 6; i++) begin
            drive_ls(1'b1, 1'b0, ld_op[i], ld_addr[i], 32'h0, 5'(i + 5));
            #1;
            check("ld_gnt", {31'd0, oLsGnt}, 32'd1);
            check("ld_err", {31'd0, oLsErr}, 32'd0);
            check("ld_ram_addr", {22'd0, oRamAddr}, 32'd1);
            exp_ls(ld_exp[i], 5'(i + 5));
            tick();
        end
        idle();
        tick();

        // SH 0x1234 to 0x6 with fetch waiting.
        bd_write(10'd1, 32'hAABBCCDD);
        drive_fetch(1'b1, 32'h0);
        drive_ls(1'b1, 1'b1, 3'b001, 32'h6, 32'hFFFF1234, 5'd0);
        #1;
        check("sh_ls_gnt", {31'd0, oLsGnt}, 32'd1);
        check("sh_fetch_gnt", {31'd0, oFetchGnt}, 32'd0);
        check("sh_rd_en", {31'd0, oRamEn}, 32'd1);
        check("sh_rd_wen", {31'd0, oRamWEn}, 32'd0);
        tick();
        iLsReq = 1'b0;
        #1;
        check("rmw_fetch_gnt", {31'd0, oFetchGnt}, 32'd0);
        check("rmw_ls_gnt", {31'd0, oLsGnt}, 32'd0);
        check("rmw_wen", {31'd0, oRamWEn}, 32'd1);
        check("rmw_addr", {22'd0, oRamAddr}, 32'd1);
        check("rmw_wdata", oRamWData, 32'h1234CCDD);
        tick();
        #1;
        check("post_rmw_fetch_gnt", {31'd0, oFetchGnt}, 32'd1);
        exp_fetch(32'hA0000000);
        tick();
        idle();
        check("sh_mem", mem[1], 32'h1234CCDD);

        // SB 0xEE to 0x5.
        drive_ls(1'b1, 1'b1, 3'b000, 32'h5, 32'h123456EE, 5'd0);
        #1;
        check("sb_gnt", {31'd0, oLsGnt}, 32'd1);
        check("sb_rd_wen", {31'd0, oRamWEn}, 32'd0);
        tick();
        idle();
        #1;
        check("sb_wdata", oRamWData, 32'h1234EEDD);
        tick();
        check("sb_mem", mem[1], 32'h1234EEDD);

        // SW is a single write cycle.
        drive_ls(1'b1, 1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 5'd0);
        #1;
        check("sw_wen", {31'd0, oRamWEn}, 32'd1);
        check("sw_wdata", oRamWData, 32'hDEADBEEF);
        tick();
        idle();
        #1;
        check("sw_done_en", {31'd0, oRamEn}, 32'd0);
        tick();
        check("sw_mem", mem[2], 32'hDEADBEEF);

        // Both requesting: LS wins 4 times, fetch on the 5th, then LS again.
        drive_fetch(1'b1, 32'h8);
        for (int i = 0; i < 6; i++) begin
            drive_ls(1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 5'(i));
            #1;
            check("stv_ls_gnt", {31'd0, oLsGnt}, (i == 4) ? 32'd0 : 32'd1);
            check("stv_fetch_gnt", {31'd0, oFetchGnt}, (i == 4) ? 32'd1 : 32'd0);
            if (i == 4) exp_fetch(32'hDEADBEEF);
            else exp_ls(32'h1234EEDD, 5'(i));
            tick();
        end
        idle();
        tick();

        // Misaligned LW with fetch: both granted, fetch owns the port.
        drive_fetch(1'b1, 32'h0);
        drive_ls(1'b1, 1'b0, 3'b010, 32'h2, 32'h0, 5'd3);
        #1;
        check("mis_ls_gnt", {31'd0, oLsGnt}, 32'd1);
        check("mis_err", {31'd0, oLsErr}, 32'd1);
        check("mis_fetch_gnt", {31'd0, oFetchGnt}, 32'd1);
        check("mis_ram_addr", {22'd0, oRamAddr}, 32'd0);
        exp_fetch(32'hA0000000);
        tick();
        drive_fetch(1'b0, 32'h0);
        drive_ls(1'b1, 1'b0, 3'b001, 32'h3, 32'h0, 5'd3);
        #1;
        check("mis_h_err", {31'd0, oLsErr}, 32'd1);
        check("mis_h_ram_en", {31'd0, oRamEn}, 32'd0);
        tick();
        idle();
        tick();

        // SB then reset during the RMW write cycle.
        drive_ls(1'b1, 1'b1, 3'b000, 32'h4, 32'h00000077, 5'd0);
        #1;
        check("rst_sb_gnt", {31'd0, oLsGnt}, 32'd1);
        tick();
        idle();
        iRst = 1'b1;
        #1;
        check("rst_rmw_wen", {31'd0, oRamWEn}, 32'd0);
        tick();
        iRst = 1'b0;
        #1;
        check("after_rst_wen", {31'd0, oRamWEn}, 32'd0);
        check("after_rst_en", {31'd0, oRamEn}, 32'd0);
        check("after_rst_wdata", oRamWData, 32'd0);
        check("after_rst_gnt", {30'd0, oFetchGnt, oLsGnt}, 32'd0);
        check("rst_mem_kept", mem[1], 32'h1234EEDD);
        drive_fetch(1'b1, 32'h4);
        #1;
        check("rst_arb_fetch_gnt", {31'd0, oFetchGnt}, 32'd1);
        exp_fetch(32'h1234EEDD);
        tick();
        idle();
        tick();

        check("fetch_q_empty", 32'(fetch_exp_q.size()), 32'd0);
        check("ls_q_empty", 32'(ls_exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
